// File: rtl/mips_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Holds the arbiter state encoding and the default abort threshold.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_BUSY = 2'd1,
        ST_IF_BUSY  = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared single memory port between the arbiter (master) and memory (slave).
interface mem_port_if;

    logic        PortReq__o;
    logic        PortWe__o;
    logic [31:0] PortAddr__o;
    logic [31:0] PortWData__o;
    logic [31:0] PortRData__i;
    logic        PortAck__i;

    modport master (
        output PortReq__o, PortWe__o, PortAddr__o, PortWData__o,
        input  PortRData__i, PortAck__i
    );

    modport slave (
        input  PortReq__o, PortWe__o, PortAddr__o, PortWData__o,
        output PortRData__i, PortAck__i
    );

endinterface

// File: rtl/arb_timeout_counter.sv
// Busy-cycle counter for the arbiter abort path (used only with MEM_ARB_TIMEOUT_EN).
// expired is asserted during the TIMEOUT_CYCLES-th consecutive counting cycle.
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock__i,
    input  logic reset__i,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;

    assign expired = start & (count_q == LAST_COUNT);

    always_ff @(posedge clock__i) begin
        if (reset__i || clear) begin
            count_q <= '0;
        end else if (start && !expired) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory port; MEM has priority.
// Optional abort on missing ack is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clock__i,
    input  logic        reset__i,
    input  logic        IFReq__i,
    input  logic [31:0] IFAddr__i,
    input  logic        MemRead__i,
    input  logic        MemWrite__i,
    input  logic [31:0] MemAddr__i,
    input  logic [31:0] MemWriteData__i,
    output logic [31:0] IFData__o,
    output logic        IFValid__o,
    output logic [31:0] MemData__o,
    output logic        MemValid__o,
    output logic        Stall__o,
    output logic        Timeout__o,
    mem_port_if.master  port
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    arb_state_e state_q, state_d;
    logic       mem_done_q, if_done_q;
    logic       mem_pend, if_pend, stall;
    logic       busy, acked, aborted, finish;
    logic       grant_mem, grant_if;
    logic       timeout_q;

    // Done flags mask a request already served until the pipeline advances.
    assign mem_pend = (MemRead__i | MemWrite__i) & ~mem_done_q;
    assign if_pend  = IFReq__i & ~if_done_q;
    assign stall    = mem_pend | if_pend;
    assign Stall__o = stall;

    assign busy   = (state_q != ST_IDLE);
    assign acked  = busy & port.PortAck__i;
    assign finish = acked | aborted;

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock__i (clock__i),
        .reset__i (reset__i),
        .start    (busy),
        .clear    (~busy),
        .expired  (expired)
    );

    // A real ack in the expiry cycle still wins.
    assign aborted = expired & ~port.PortAck__i;

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            timeout_q <= 1'b0;
        end else if (aborted) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign aborted   = 1'b0;
    assign timeout_q = 1'b0;
`endif

    assign Timeout__o = timeout_q;

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_pend) begin
                    state_d   = ST_MEM_BUSY;
                    grant_mem = 1'b1;
                end else if (if_pend) begin
                    state_d  = ST_IF_BUSY;
                    grant_if = 1'b1;
                end
            end
            ST_MEM_BUSY, ST_IF_BUSY: begin
                if (finish) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            port.PortReq__o   <= 1'b0;
            port.PortWe__o    <= 1'b0;
            port.PortAddr__o  <= '0;
            port.PortWData__o <= '0;
            MemData__o        <= '0;
            MemValid__o       <= 1'b0;
            IFData__o         <= '0;
            IFValid__o        <= 1'b0;
            mem_done_q        <= 1'b0;
            if_done_q         <= 1'b0;
        end else begin
            MemValid__o <= 1'b0;
            IFValid__o  <= 1'b0;
            mem_done_q  <= stall & mem_done_q;
            if_done_q   <= stall & if_done_q;

            if (grant_mem) begin
                port.PortReq__o   <= 1'b1;
                port.PortWe__o    <= MemWrite__i;
                port.PortAddr__o  <= MemAddr__i;
                port.PortWData__o <= MemWriteData__i;
            end else if (grant_if) begin
                port.PortReq__o   <= 1'b1;
                port.PortWe__o    <= 1'b0;
                port.PortAddr__o  <= IFAddr__i;
                port.PortWData__o <= '0;
            end else if (finish) begin
                port.PortReq__o <= 1'b0;
            end

            // An aborted access completes with zero data.
            if (finish && state_q == ST_MEM_BUSY) begin
                MemValid__o <= 1'b1;
                mem_done_q  <= stall;
                if (!port.PortWe__o) MemData__o <= acked ? port.PortRData__i : '0;
            end
            if (finish && state_q == ST_IF_BUSY) begin
                IFValid__o <= 1'b1;
                if_done_q  <= stall;
                IFData__o  <= acked ? port.PortRData__i : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock__i = 1'b0;
    logic        reset__i = 1'b1;
    logic        IFReq__i = 1'b0;
    logic [31:0] IFAddr__i = '0;
    logic        MemRead__i = 1'b0;
    logic        MemWrite__i = 1'b0;
    logic [31:0] MemAddr__i = '0;
    logic [31:0] MemWriteData__i = '0;
    logic [31:0] IFData__o, MemData__o;
    logic        IFValid__o, MemValid__o, Stall__o, Timeout__o;

    mem_port_if pif ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock__i        (clock__i),
        .reset__i        (reset__i),
        .IFReq__i        (IFReq__i),
        .IFAddr__i       (IFAddr__i),
        .MemRead__i      (MemRead__i),
        .MemWrite__i     (MemWrite__i),
        .MemAddr__i      (MemAddr__i),
        .MemWriteData__i (MemWriteData__i),
        .IFData__o       (IFData__o),
        .IFValid__o      (IFValid__o),
        .MemData__o      (MemData__o),
        .MemValid__o     (MemValid__o),
        .Stall__o        (Stall__o),
        .Timeout__o      (Timeout__o),
        .port            (pif.master)
    );

    always #5 clock__i = ~clock__i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory slave: acks the ack_delay-th request cycle of each access.
    int          ack_delay = 1;
    int          cur_delay = 1;
    int          req_cnt   = 0;
    bit          rand_mode = 1'b0;
    bit          spur_en   = 1'b0;
    bit          force_spur = 1'b0;
    logic [31:0] dir_rdata = '0;

    initial begin
        pif.PortAck__i   = 1'b0;
        pif.PortRData__i = '0;
        forever begin
            @(posedge clock__i);
            #1;
            if (pif.PortReq__o === 1'b1) begin
                req_cnt++;
                if (req_cnt == 1) cur_delay = rand_mode ? int'($urandom_range(1, 3)) : ack_delay;
                pif.PortAck__i = (req_cnt == cur_delay);
            end else begin
                req_cnt = 0;
                pif.PortAck__i = spur_en ? ($urandom_range(0, 3) == 0) : force_spur;
            end
            pif.PortRData__i = rand_mode ? $urandom : dir_rdata;
        end
    end

    // Log of accesses issued on the port: {we, addr}.
    logic [32:0] issue_log[$];
    logic        prev_req = 1'b0;
    always @(negedge clock__i) begin
        if (pif.PortReq__o === 1'b1 && !prev_req) issue_log.push_back({pif.PortWe__o, pif.PortAddr__o});
        prev_req <= (pif.PortReq__o === 1'b1);
    end

    // Reference model: who owns the port, for how long, and what each requester must see next.
    bit          chk_en = 1'b0;
    int          m_owner = 0;  // 0 none, 1 MEM, 2 IF
    int          m_busy  = 0;
    bit          m_md = 0, m_id = 0;
    bit          e_req = 0, e_we = 0, e_mv = 0, e_iv = 0, e_to = 0;
    logic [31:0] e_addr = '0, e_wd = '0, e_mdata = '0, e_idata = '0;
    bit          mp, ip, st, ack, fin, sm, si;
    logic [31:0] d;

    initial begin
        forever begin
            @(negedge clock__i);
            if (chk_en) begin
                chk("PortReq", pif.PortReq__o, e_req);
                chk("MemValid", MemValid__o, e_mv);
                chk("IFValid", IFValid__o, e_iv);
                chk("MemData", MemData__o, e_mdata);
                chk("IFData", IFData__o, e_idata);
                chk("Timeout", Timeout__o, e_to);
                if (e_req) begin
                    chk("PortWe", pif.PortWe__o, e_we);
                    chk("PortAddr", pif.PortAddr__o, e_addr);
                    if (e_we) chk("PortWData", pif.PortWData__o, e_wd);
                end
            end
            mp = (MemRead__i || MemWrite__i) && !m_md;
            ip = IFReq__i && !m_id;
            st = mp || ip;
            if (chk_en) chk("Stall", Stall__o, st);
            if (reset__i) begin
                m_owner = 0; m_busy = 0; m_md = 0; m_id = 0;
                e_req = 0; e_we = 0; e_mv = 0; e_iv = 0; e_to = 0;
                e_addr = '0; e_wd = '0; e_mdata = '0; e_idata = '0;
                chk_en = 1'b1;
            end else begin
                e_mv = 0; e_iv = 0; sm = 0; si = 0;
                if (m_owner == 0) begin
                    if (mp) begin
                        m_owner = 1; e_req = 1; e_we = MemWrite__i;
                        e_addr = MemAddr__i; e_wd = MemWriteData__i;
                    end else if (ip) begin
                        m_owner = 2; e_req = 1; e_we = 0; e_addr = IFAddr__i;
                    end
                end else begin
                    m_busy++;
                    ack = pif.PortAck__i;
                    fin = ack || (TO_EN && m_busy >= TMO);
                    if (fin) begin
                        d = ack ? pif.PortRData__i : 32'h0;
                        if (m_owner == 1) begin
                            e_mv = 1; sm = 1;
                            if (!e_we) e_mdata = d;
                        end else begin
                            e_iv = 1; si = 1; e_idata = d;
                        end
                        if (!ack) e_to = 1;
                        m_owner = 0; m_busy = 0; e_req = 0;
                    end
                end
                m_md = st && (m_md || sm);
                m_id = st && (m_id || si);
            end
        end
    end

    // Directed operation: hold requests while stalled, record what the requester saw.
    int          r_stall, r_mv, r_iv, r_mv_at, r_iv_at;
    logic [31:0] r_mdata, r_idata;
    bit          r_done;

    task automatic do_op(input bit ifr, input logic [31:0] ia, input bit mr, input bit mw,
                         input logic [31:0] ma, input logic [31:0] md);
        r_stall = 0; r_mv = 0; r_iv = 0; r_mv_at = -1; r_iv_at = -1; r_done = 0;
        r_mdata = 'x; r_idata = 'x;
        IFReq__i = ifr; IFAddr__i = ia; MemRead__i = mr; MemWrite__i = mw;
        MemAddr__i = ma; MemWriteData__i = md;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock__i);
            if (MemValid__o) begin r_mv++; r_mv_at = cyc; r_mdata = MemData__o; end
            if (IFValid__o)  begin r_iv++; r_iv_at = cyc; r_idata = IFData__o; end
            if (Stall__o) r_stall++;
            else begin r_done = 1; break; end
            @(posedge clock__i);
            #1;
        end
        chk("op_completes", r_done, 1'b1);
        @(posedge clock__i);
        #1;
        IFReq__i = 0; MemRead__i = 0; MemWrite__i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock__i);
        #1;
    endtask

    int vcount;
    bit stall_q;

    initial begin
        idle(2);
        reset__i = 0;
        @(negedge clock__i);
        chk("rst_PortReq", pif.PortReq__o, 0);
        chk("rst_PortWe", pif.PortWe__o, 0);
        chk("rst_PortAddr", pif.PortAddr__o, 0);
        chk("rst_PortWData", pif.PortWData__o, 0);
        chk("rst_MemValid", MemValid__o, 0);
        chk("rst_IFValid", IFValid__o, 0);
        chk("rst_MemData", MemData__o, 0);
        chk("rst_IFData", IFData__o, 0);
        chk("rst_Timeout", Timeout__o, 0);
        chk("rst_Stall", Stall__o, 0);
        idle(1);

        // Read with ack on the third request cycle.
        issue_log.delete();
        ack_delay = 3; dir_rdata = 32'hCAFEF00D;
        do_op(0, 0, 1, 0, 32'h100, 0);
        chk("rd_stall_cycles", r_stall, 4);
        chk("rd_valid_pulses", r_mv, 1);
        chk("rd_data", r_mdata, 32'hCAFEF00D);
        chk("rd_issue_addr", issue_log[0], {1'b0, 32'h100});
        idle(2);

        // Write and fetch together: MEM goes first, stall ends with IFValid.
        issue_log.delete();
        ack_delay = 2; dir_rdata = 32'h0000_2400;
        do_op(1, 32'h200, 0, 1, 32'h40, 32'h12345678);
        chk("wf_issue_count", issue_log.size(), 2);
        chk("wf_first_mem_write", issue_log[0], {1'b1, 32'h40});
        chk("wf_second_if", issue_log[1], {1'b0, 32'h200});
        chk("wf_mem_valid", r_mv, 1);
        chk("wf_if_valid", r_iv, 1);
        chk("wf_stall_ends_at_ifvalid", r_iv_at, r_stall);
        chk("wf_stall_cycles", r_stall, 6);
        chk("wf_memdata_kept", r_mdata, 32'hCAFEF00D);
        chk("wf_if_data", r_idata, 32'h0000_2400);
        idle(2);

        // Zero-wait ack, no re-issue of the still-asserted request.
        issue_log.delete();
        ack_delay = 1; dir_rdata = 32'h0BADBEEF;
        do_op(0, 0, 1, 0, 32'h80, 0);
        chk("zw_valid_cycle", r_mv_at, 2);
        chk("zw_stall_cycles", r_stall, 2);
        chk("zw_data", r_mdata, 32'h0BADBEEF);
        idle(3);
        chk("zw_no_reissue", issue_log.size(), 1);

        // Reset in the middle of a MEM access.
        ack_delay = 0;
        MemRead__i = 1; MemAddr__i = 32'h500;
        idle(3);
        chk("mr_busy_before_reset", pif.PortReq__o, 1);
        reset__i = 1; MemRead__i = 0;
        idle(1);
        reset__i = 0;
        vcount = 0;
        @(negedge clock__i);
        chk("mr_portreq_dropped", pif.PortReq__o, 0);
        repeat (3) begin
            @(negedge clock__i);
            vcount += int'(MemValid__o) + int'(IFValid__o) + int'(pif.PortReq__o);
        end
        chk("mr_no_valid_no_req", vcount, 0);
        idle(1);

        // Spurious acks while idle.
        issue_log.delete();
        force_spur = 1; vcount = 0;
        repeat (4) begin
            @(negedge clock__i);
            vcount += int'(MemValid__o) + int'(IFValid__o) + int'(pif.PortReq__o);
        end
        force_spur = 0;
        chk("sp_nothing_happens", vcount, 0);
        chk("sp_no_issue", issue_log.size(), 0);
        idle(1);
        ack_delay = 1; dir_rdata = 32'h7777_0001;
        do_op(1, 32'h44, 0, 0, 0, 0);
        chk("sp_then_fetch", r_idata, 32'h7777_0001);
        idle(2);

        // Randomized traffic, including withdrawals and occasional resets.
        rand_mode = 1; spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock__i);
            stall_q = Stall__o;
            @(posedge clock__i);
            #1;
            reset__i = ($urandom_range(0, 299) == 0);
            if (!stall_q || $urandom_range(0, 15) == 0) begin
                IFReq__i        = ($urandom_range(0, 9) < 6);
                MemRead__i      = ($urandom_range(0, 2) == 0);
                MemWrite__i     = ($urandom_range(0, 3) == 0);
                IFAddr__i       = $urandom;
                MemAddr__i      = $urandom;
                MemWriteData__i = $urandom;
            end
        end
        reset__i = 0; IFReq__i = 0; MemRead__i = 0; MemWrite__i = 0;
        idle(8);
        rand_mode = 0; spur_en = 0;
        idle(2);

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack: abort after TMO busy cycles with zero data.
        ack_delay = 0;
        do_op(0, 0, 1, 0, 32'h300, 0);
        chk("to_stall_cycles", r_stall, TMO + 1);
        chk("to_valid", r_mv, 1);
        chk("to_zero_data", r_mdata, 32'h0);
        chk("to_flag_set", Timeout__o, 1);
        idle(5);
        chk("to_flag_sticky", Timeout__o, 1);
        reset__i = 1;
        idle(1);
        reset__i = 0;
        @(negedge clock__i);
        chk("to_flag_cleared", Timeout__o, 0);
        ack_delay = 1;
        idle(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning max busy cycles awaiting PortAck__i before abort (range 2..65535).
REQ-002 SHALL have: clock__i  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have: reset__i  in  1  synchronous, active-high reset.
REQ-004 SHALL have: IFReq__i in 1 fetch request; IFAddr__i in 32 fetch address.
REQ-005 SHALL have: MemRead__i in 1, MemWrite__i in 1 (from EX/MEM register); MemAddr__i in 32 (ALU result); MemWriteData__i in 32.
REQ-006 SHALL have: IFData__o out 32, IFValid__o out 1; MemData__o out 32, MemValid__o out 1.
REQ-007 SHALL have: Stall__o  out  1  freeze of all pipeline registers.
REQ-008 SHALL have: PortReq__o out 1, PortWe__o out 1, PortAddr__o out 32, PortWData__o out 32, PortRData__i in 32, PortAck__i in 1 (shared single memory port).
REQ-009 SHALL have: Timeout__o  out  1  sticky abort flag.

Function
REQ-010 SHALL implement FSM IDLE, MEM_BUSY, IF_BUSY.
REQ-011 In IDLE, SHALL grant MEM if (MemRead__i|MemWrite__i) & ~mem_done, else IF if IFReq__i & ~if_done; MEM always wins.
REQ-012 On grant, SHALL latch address, write data, and PortWe__o (=MemWrite__i for MEM, 0 for IF); PortReq__o rises the next cycle.
REQ-013 In BUSY, SHALL hold PortReq__o=1 and all Port* fields stable until PortAck__i=1 is sampled.
REQ-014 On ack, SHALL register PortRData__i into the granted requester's data output, pulse its Valid one cycle, set its done flag, and return to IDLE; PortReq__o drops in the same cycle as Valid.
REQ-015 Writes SHALL pulse MemValid__o; MemData__o is unchanged on writes.
REQ-016 Stall__o SHALL equal ((MemRead__i|MemWrite__i) & ~mem_done) | (IFReq__i & ~if_done), combinational from registered flags.
REQ-017 Both done flags SHALL clear on any cycle where Stall__o=0.
REQ-018 Minimum latency: request at cycle 0, PortReq__o at cycle 1, ack at cycle 1 -> Valid and Stall__o=0 at cycle 2.
REQ-019 MemRead__i and MemWrite__i both high SHALL be treated as a write.
REQ-020 PortAck__i in IDLE SHALL be ignored.
REQ-021 Requests withdrawn while BUSY SHALL not abort the transaction; the result is delivered and discarded.

Reset
REQ-022 On reset__i=1, SHALL enter IDLE; all outputs 0 (PortReq__o, PortWe__o, Valids, Timeout__o, data/address buses); both done flags and timeout counter 0.
REQ-023 Reset mid-transaction SHALL drop PortReq__o on the next edge; no Valid is issued for the abandoned access.

Configuration
REQ-024 With MEM_ARB_TIMEOUT_EN defined: a busy-cycle counter SHALL abort after TIMEOUT_CYCLES without ack, drop PortReq__o, complete the requester with data 32'h0 and a Valid pulse, and set Timeout__o sticky until reset.
REQ-025 Without MEM_ARB_TIMEOUT_EN: the arbiter SHALL wait indefinitely for ack; Timeout__o is tied 0; the port remains present.

Structure
REQ-026 The state enum typedef and the default TIMEOUT_CYCLES constant SHALL reside in shared package mips_pkg.
REQ-027 The timeout counter SHALL be sub-module arb_timeout_counter (start, clear, expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-028 MEM read 0x100, ack after 3 cycles with 0xCAFEF00D -> MemData__o=0xCAFEF00D, one MemValid__o pulse, Stall__o high exactly 4 cycles.
REQ-029 IFReq__i and MemWrite__i in the same cycle (addr 0x40, data 0x12345678) -> MEM issued first with PortWe__o=1, then IF; Stall__o deasserts only after IFValid__o.
REQ-030 Zero-wait ack -> Valid at cycle 2; Stall__o low at cycle 2; no re-issue while the frozen request remains asserted.
REQ-031 reset__i asserted during MEM_BUSY -> PortReq__o=0 next cycle, no Valid, state IDLE.
REQ-032 MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> abort after 4 busy cycles, MemData__o=0, Timeout__o=1 held until reset.
REQ-033 Spurious PortAck__i in IDLE -> no Valid, no state change.
